// File: rtl/instruction_fetch.sv
// instruction_fetch: PC/IR fetch stage with branch redirect, stall, halt and sticky address fault.
module instruction_fetch #(
  parameter logic [23:0] RESET_PC = 24'h000000,
  parameter int MEM_BYTES = 128
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [23:0] BranchTarget,
  input  logic [23:0] InstrIn,
  output logic [23:0] PC,
  output logic [23:0] InstrOut,
  output logic [23:0] PCOut,
  output logic [23:0] PCPlus3,
  output logic        Valid,
  output logic        Halted,
  output logic        Fault,
  output logic [15:0] FetchCount
);
  typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
  localparam logic [23:0] LAST_PC = 24'(MEM_BYTES - 3);
  state_t state, state_n;
  logic [23:0] pc_n, ir_n, pc_out_n;
  logic [15:0] cnt_n;
  logic valid_n, halt_op;
  assign halt_op = InstrIn[23:20] == 4'hF;
  always_comb begin
    state_n = state;
    pc_n = PC;
    ir_n = InstrOut;
    pc_out_n = PCOut;
    cnt_n = FetchCount;
    valid_n = 1'b0;
    if (state == RUN) begin
      if (PC > LAST_PC) state_n = FAULT;
      else if (BranchTaken) pc_n = BranchTarget;
      else if (Stall) valid_n = Valid;
      else begin
        ir_n = InstrIn;
        pc_out_n = PC;
        valid_n = 1'b1;
        cnt_n = &FetchCount ? FetchCount : FetchCount + 16'd1;
        pc_n = halt_op ? PC : PC + 24'd3;
        state_n = halt_op ? HALT : RUN;
      end
    end
  end
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= RUN;
      PC <= RESET_PC;
      InstrOut <= '0;
      PCOut <= '0;
      Valid <= 1'b0;
      FetchCount <= '0;
    end else begin
      state <= state_n;
      PC <= pc_n;
      InstrOut <= ir_n;
      PCOut <= pc_out_n;
      Valid <= valid_n;
      FetchCount <= cnt_n;
    end
  end
  assign PCPlus3 = PCOut + 24'd3;
  assign Halted = state == HALT;
  assign Fault = state == FAULT;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: random and directed checks of instruction_fetch against a rule-level model.
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0, br = 1'b0;
  logic [23:0] tgt = '0;
  logic [23:0] imem [0:255];
  logic [23:0] pc, ir, pc_out, pc_p3, s_pc, s_ir, s_pco, s_pp3;
  logic valid, halted, fault, s_valid, s_halted, s_fault;
  logic [15:0] cnt, s_cnt;
  int tests = 0, fails = 0;
  logic [23:0] m_pc, m_ir, m_pcout;
  logic m_valid;
  logic [15:0] m_cnt;
  int m_mode;
  always #5 clk = ~clk;
  instruction_fetch dut (
    .Clock(clk), .Reset(rst_n), .Stall(stall), .BranchTaken(br), .BranchTarget(tgt),
    .InstrIn(imem[pc[7:0]]), .PC(pc), .InstrOut(ir), .PCOut(pc_out), .PCPlus3(pc_p3),
    .Valid(valid), .Halted(halted), .Fault(fault), .FetchCount(cnt)
  );
  instruction_fetch #(.MEM_BYTES(1 << 24)) sat (
    .Clock(clk), .Reset(rst_n), .Stall(1'b0), .BranchTaken(1'b0), .BranchTarget(24'h0),
    .InstrIn({4'h1, s_pc[19:0]}), .PC(s_pc), .InstrOut(s_ir), .PCOut(s_pco), .PCPlus3(s_pp3),
    .Valid(s_valid), .Halted(s_halted), .Fault(s_fault), .FetchCount(s_cnt)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_pc = 24'h0; m_ir = '0; m_pcout = '0; m_valid = 1'b0; m_cnt = '0; m_mode = 0;
  endtask
  // Mode 0 runs, 1 is halted, 2 is faulted; only memory 0..125 may be fetched.
  task automatic m_step();
    logic [23:0] w;
    w = imem[m_pc[7:0]];
    if (m_mode != 0) m_valid = 1'b0;
    else if (m_pc > 24'd125) begin m_mode = 2; m_valid = 1'b0; end
    else if (br) begin m_pc = tgt; m_valid = 1'b0; end
    else if (!stall) begin
      m_ir = w; m_pcout = m_pc; m_valid = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      if (w[23:20] == 4'hF) m_mode = 1;
      else m_pc = (m_pc + 3) % 24'hFFFFFF;
      if (w[23:20] != 4'hF && m_pc == 24'h0 && m_pcout == 24'hFFFFFC) m_pc = 24'h0;
    end
  endtask
  task automatic chk_all(input string tag);
    chk(tag, {pc, ir, pc_out, pc_p3, valid, halted, fault, cnt},
        {m_pc, m_ir, m_pcout, m_pcout + 24'd3, m_valid, m_mode == 1, m_mode == 2, m_cnt});
  endtask
  task automatic cyc(input logic s, input logic b, input logic [23:0] t, input string tag);
    stall = s; br = b; tgt = t;
    m_step();
    @(posedge clk); #1;
    chk_all(tag);
  endtask
  task automatic do_reset();
    rst_n = 1'b0; stall = 0; br = 0;
    m_reset();
    #2;
    chk_all("reset");
    @(negedge clk) rst_n = 1'b1;
  endtask
  task automatic fill_plain();
    for (int i = 0; i < 256; i++) imem[i] = {4'h2, 20'($urandom)};
  endtask
  initial begin
    fill_plain();
    imem[0] = 24'h111111; imem[3] = 24'h222222; imem[6] = 24'hF00000;
    do_reset();
    cyc(0, 0, 0, "seq1");
    chk("seq1_fields", {ir, pc_out, valid, pc}, {24'h111111, 24'h0, 1'b1, 24'h3});
    cyc(0, 0, 0, "seq2");
    chk("seq2_fields", {ir, pc_p3, cnt}, {24'h222222, 24'h6, 16'd2});
    cyc(0, 0, 0, "halt_issue");
    chk("halt_issue_fields", {valid, halted, pc}, {1'b1, 1'b1, 24'h6});
    cyc(0, 0, 0, "halt_next");
    chk("halt_next_valid", valid, 1'b0);
    for (int i = 0; i < 4; i++) cyc(i[0], 1'b1, 24'h30, "halt_ign");
    chk("halt_ign_pc", {pc, halted, cnt}, {24'h6, 1'b1, 16'd3});
    fill_plain();
    do_reset();
    cyc(0, 0, 0, "sb_fetch");
    cyc(1, 0, 0, "stall1");
    cyc(1, 0, 0, "stall2");
    chk("stall_held", {pc, ir, cnt}, {24'h3, imem[0], 16'd1});
    cyc(1, 1, 24'h30, "stall_br");
    chk("stall_br_fields", {pc, valid}, {24'h30, 1'b0});
    cyc(0, 0, 0, "after_br");
    chk("after_br_fields", {pc_out, valid}, {24'h30, 1'b1});
    cyc(0, 1, 24'h7E, "br_7e");
    cyc(0, 0, 0, "fault");
    chk("fault_fields", {fault, valid, halted}, {1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) cyc(1'($urandom), 1'($urandom), 24'h0, "fault_hold");
    chk("fault_persist", {fault, pc}, {1'b1, 24'h7E});
    do_reset();
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, "pre_async");
    chk("pre_async_fields", {valid, cnt}, {1'b1, 16'd5});
    #2 rst_n = 1'b0;
    m_reset();
    #1 chk_all("async_reset");
    chk("async_fields", {pc, ir, pc_out, valid, halted, fault, cnt}, 91'h0);
    @(negedge clk) rst_n = 1'b1;
    cyc(0, 0, 0, "post_async");
    chk("post_async_fields", {pc_out, valid}, {24'h0, 1'b1});
    for (int e = 0; e < 12; e++) begin
      for (int i = 0; i < 256; i++) imem[i] = 24'($urandom);
      do_reset();
      for (int i = 0; i < 200; i++)
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 24'($urandom_range(0, 130)), "rand");
    end
    do_reset();
    repeat (65534) @(posedge clk);
    #1 chk("sat_fffe", {s_cnt, s_valid}, {16'hFFFE, 1'b1});
    @(posedge clk); #1 chk("sat_ffff", s_cnt, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 chk("sat_hold", {s_cnt, s_valid, s_fault}, {16'hFFFF, 1'b1, 1'b0});
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
